st_packet_rr_arbiter: RTL and testbench
=======================================

// Module: st_packet_rr_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter that shares one 32-bit Avalon-ST sink (the 32->8 byte
//  serializer feeding the decoder byte path) between NUM_SRC 32-bit stream sources.
//  Grant is locked from first accepted beat until the beat with endofpacket; payload is
//  registered once and forwarded unchanged (data, sop, eop, empty).
// PARAMETERS
//  NUM_SRC   2   number of requesting sources, 2..4
//  DATA_W    32  beat width in bits
//  EMPTY_W   2   width of empty field (log2(DATA_W/8))
// PORTS
//  clk        in   1                  clock
//  reset_n    in   1                  asynchronous, active-low reset
//  in_valid   in   NUM_SRC            per-source valid
//  in_ready   out  NUM_SRC            per-source ready (combinational)
//  in_data    in   NUM_SRC*DATA_W     source i at [i*DATA_W +: DATA_W]
//  in_sop     in   NUM_SRC            startofpacket
//  in_eop     in   NUM_SRC            endofpacket
//  in_empty   in   NUM_SRC*EMPTY_W    empty bytes, valid with eop
//  out_valid  out  1                  registered
//  out_ready  in   1                  sink ready
//  out_data   out  DATA_W             registered
//  out_sop    out  1                  registered
//  out_eop    out  1                  registered
//  out_empty  out  EMPTY_W            registered
//  grant      out  NUM_SRC            one-hot current owner, 0 in IDLE
//  sop_err    out  1                  sticky: first beat of a grant lacked sop
// BEHAVIOUR
//  - Reset: out_valid/out_sop/out_eop/sop_err=0, out_data/out_empty=0, grant=0, state IDLE,
//    rr pointer=0; in_ready=0 while reset asserted.
//  - adv = out_ready | ~out_valid; output register loads only when adv.
//  - IDLE: if any in_valid, pick first requester at or after pointer (wrapping), load grant,
//    -> BUSY next cycle. No beat accepted in IDLE (1-cycle arbitration bubble).
//  - BUSY: in_ready[g] = adv for granted g, 0 for all others. Beat accepted when
//    in_valid[g] & in_ready[g]; appears on out_* next cycle (latency 1).
//  - Accepted beat with eop: grant->0, pointer = g+1 mod NUM_SRC, -> IDLE.
//  - Single-beat packet (sop&eop together): one beat, then IDLE; same rule.
//  - Granted source deasserting valid mid-packet: grant held, out_valid drops when
//    sink drains; no switch until eop.
//  - Other sources' valid/sop ignored while BUSY; they are never acknowledged.
//  - First accepted beat of a grant with in_sop=0: still forwarded, sop_err set
//    (cleared only by reset).
//  - out_ready low with out_valid high: out_* held stable, in_ready=0.
//  - reset mid-packet: immediate return to reset state; partial packet discarded, sink
//    sees out_valid=0.
//  - Empty forwarded as-is; not checked when eop=0.
// CONFIGURATION
//  ST_ARB_CHANNEL_EN defined: extra port out_channel out $clog2(NUM_SRC), registered with
//    out_data, carries granted source index; reset 0.
//  Undefined: port absent; sources indistinguishable downstream.
// STRUCTURE
//  - Package st_arb_pkg: state typedef {IDLE,BUSY}, NUM_SRC_MAX=4, rr pick function.
//  - Sub-module st_rr_pick: combinational (req, pointer) -> one-hot grant; reused elsewhere.
// TESTING
//  - Reset: reset_n low -> all outputs 0, in_ready=0; release -> IDLE, grant=0.
//  - Src0 3-beat pkt 0x11223344,0x55667788,0x99AABBCC eop empty=2 -> 3 beats in order,
//    out_eop on 3rd with out_empty=2, then grant=0.
//  - Src0,src1 both valid continuously -> grants alternate 0,1,0,1; no interleaving within
//    any packet.
//  - out_ready low 5 cycles mid-packet -> out_data stable, in_ready=0, no beat lost/duplicated.
//  - Src1 first beat sop=0 -> beat forwarded, sop_err=1 and stays 1 until reset.
//  - reset_n pulse after beat 2 of 4 -> outputs cleared, next grant goes to src0 (pointer 0).

Source files
------------

// File: rtl/st_arb_pkg.sv
// Shared types and the round-robin pick helper for the packet arbiter slice.
package st_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NUM_SRC_MAX = 4;

    // Returns a one-hot grant for the first requester at or after ptr, wrapping at n.
    function automatic logic [NUM_SRC_MAX-1:0] rr_pick(
        input logic [NUM_SRC_MAX-1:0] req,
        input logic [1:0]             ptr,
        input int                     n
    );
        logic [NUM_SRC_MAX-1:0] gnt;
        logic                   found;
        int                     idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC_MAX; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[1:0]]) begin
                    gnt[idx[1:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/st_rr_pick.sv
// Combinational round-robin picker: (req, pointer) -> one-hot grant.
module st_rr_pick
    import st_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] ptr,
    output logic [NUM_SRC-1:0]         grant
);

    assign grant = NUM_SRC'(rr_pick(NUM_SRC_MAX'(req), 2'(ptr), NUM_SRC));

endmodule

// File: rtl/st_packet_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one Avalon-ST sink between NUM_SRC sources.
// Optional ST_ARB_CHANNEL_EN adds out_channel carrying the granted source index.
module st_packet_rr_arbiter
    import st_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_SRC-1:0]           in_valid,
    output logic [NUM_SRC-1:0]           in_ready,
    input  logic [NUM_SRC*DATA_W-1:0]    in_data,
    input  logic [NUM_SRC-1:0]           in_sop,
    input  logic [NUM_SRC-1:0]           in_eop,
    input  logic [NUM_SRC*EMPTY_W-1:0]   in_empty,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [EMPTY_W-1:0]           out_empty,
`ifdef ST_ARB_CHANNEL_EN
    output logic [$clog2(NUM_SRC)-1:0]   out_channel,
`endif
    output logic [NUM_SRC-1:0]           grant,
    output logic                         sop_err
);

    localparam int PTR_W = $clog2(NUM_SRC);

    state_t               state, state_next;
    logic [NUM_SRC-1:0]   grant_next, pick;
    logic [PTR_W-1:0]     ptr, ptr_next, idx, idx_next, pick_idx;
    logic                 first_beat, first_next;
    logic                 adv, accept;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_sop, sel_eop;
    logic [EMPTY_W-1:0]   sel_empty;

    st_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (pick)
    );

    assign adv       = out_ready | ~out_valid;
    assign sel_data  = in_data[idx*DATA_W +: DATA_W];
    assign sel_sop   = in_sop[idx];
    assign sel_eop   = in_eop[idx];
    assign sel_empty = in_empty[idx*EMPTY_W +: EMPTY_W];
    assign accept    = (state == BUSY) & adv & in_valid[idx];
    assign in_ready  = (state == BUSY && adv) ? grant : '0;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // Grant is taken in IDLE and only released by an accepted end-of-packet beat.
    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        idx_next   = idx;
        first_next = first_beat;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    state_next = BUSY;
                    grant_next = pick;
                    idx_next   = pick_idx;
                    first_next = 1'b1;
                end
            end
            BUSY: begin
                if (accept) begin
                    first_next = 1'b0;
                    if (sel_eop) begin
                        state_next = IDLE;
                        grant_next = '0;
                        ptr_next   = (idx == PTR_W'(NUM_SRC-1)) ? '0 : idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            ptr        <= '0;
            idx        <= '0;
            first_beat <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            ptr        <= ptr_next;
            idx        <= idx_next;
            first_beat <= first_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_empty   <= '0;
`ifdef ST_ARB_CHANNEL_EN
            out_channel <= '0;
`endif
            sop_err     <= 1'b0;
        end else begin
            if (adv) begin
                out_valid <= accept;
                if (accept) begin
                    out_data    <= sel_data;
                    out_sop     <= sel_sop;
                    out_eop     <= sel_eop;
                    out_empty   <= sel_empty;
`ifdef ST_ARB_CHANNEL_EN
                    out_channel <= idx;
`endif
                end
            end
            if (accept && first_beat && !sel_sop) sop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_st_packet_rr_arbiter.sv
// Directed self-checking bench for st_packet_rr_arbiter (NUM_SRC=2).
module tb_st_packet_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  in_valid, in_ready, in_sop, in_eop, grant;
    logic [63:0] in_data;
    logic [3:0]  in_empty;
    logic        out_valid, out_ready, out_sop, out_eop, sop_err;
    logic [31:0] out_data;
    logic [1:0]  out_empty;
`ifdef ST_ARB_CHANNEL_EN
    logic        out_channel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    st_packet_rr_arbiter #(.NUM_SRC(2), .DATA_W(32), .EMPTY_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
`ifdef ST_ARB_CHANNEL_EN
        .out_channel(out_channel),
`endif
        .grant(grant), .sop_err(sop_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int s, input logic v, input logic [31:0] d,
                                 input logic sop, input logic eop, input logic [1:0] e);
        in_valid[s]        = v;
        in_data[s*32 +: 32] = d;
        in_sop[s]          = sop;
        in_eop[s]          = eop;
        in_empty[s*2 +: 2] = e;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] altBeat(input int k);
        int src, pkt, b;
        src = (k / 2) % 2;
        pkt = k / 4;
        b   = k % 2;
        return {(b == 0), (b == 1), 8'(src), 8'(pkt), 16'(b)};
    endfunction

    logic [33:0] obs [16];
    int          nobs;
    logic [1:0]  fire;
    int          bidx [2];
    int          pidx [2];

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
        applyStimulus(0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 2'd0);

        // Reset state, with a requester present
        tick; tick;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_flags", 64'({out_sop, out_eop, out_empty}), 64'd0);
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_sop_err", 64'(sop_err), 64'd0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b1;
        tick;
        checkOutput("idle_grant", 64'(grant), 64'd0);

        // Src0 3-beat packet, sink always ready
        $display("[TB] src0 three-beat packet");
        applyStimulus(0, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 2'd0);
        tick;
        checkOutput("p3_grant", 64'(grant), 64'd1);
        checkOutput("p3_bubble_valid", 64'(out_valid), 64'd0);
        checkOutput("p3_in_ready", 64'(in_ready), 64'd1);
        tick;
        checkOutput("p3_b0", 64'({out_valid, out_sop, out_eop, out_data}), {29'd0, 3'b110, 32'h1122_3344});
        applyStimulus(0, 1'b1, 32'h5566_7788, 1'b0, 1'b0, 2'd0);
        tick;
        checkOutput("p3_b1", 64'({out_valid, out_sop, out_eop, out_data}), {29'd0, 3'b100, 32'h5566_7788});
        applyStimulus(0, 1'b1, 32'h99AA_BBCC, 1'b0, 1'b1, 2'd2);
        tick;
        checkOutput("p3_b2", 64'({out_valid, out_sop, out_eop, out_data}), {29'd0, 3'b101, 32'h99AA_BBCC});
        checkOutput("p3_empty", 64'(out_empty), 64'd2);
        checkOutput("p3_grant_rel", 64'(grant), 64'd0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        tick;
        checkOutput("p3_drain", 64'(out_valid), 64'd0);

        // Reset so the pointer is back at src0, then both sources request continuously
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
        $display("[TB] alternating two-source traffic");
        nobs = 0;
        for (int s = 0; s < 2; s++) begin
            bidx[s] = 0; pidx[s] = 0;
            applyStimulus(s, 1'b1, {8'(s), 8'd0, 16'd0}, 1'b1, 1'b0, 2'd0);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            fire = in_valid & in_ready;
            if (out_valid && out_ready && nobs < 16) begin
                obs[nobs] = {out_sop, out_eop, out_data};
                nobs++;
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (fire[s]) begin
                    bidx[s]++;
                    if (bidx[s] == 2) begin bidx[s] = 0; pidx[s]++; end
                    applyStimulus(s, pidx[s] < 3, {8'(s), 8'(pidx[s]), 16'(bidx[s])},
                                  bidx[s] == 0, bidx[s] == 1, 2'd0);
                end
            end
        end
        checkOutput("alt_count", 64'(nobs), 64'd12);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("alt_beat%0d", k), 64'(obs[k]), 64'(altBeat(k)));
        end
        tick;

        // Sink stalls for 5 cycles mid-packet
        $display("[TB] sink backpressure");
        applyStimulus(0, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 2'd0);
        tick;
        checkOutput("bp_grant", 64'(grant), 64'd1);
        tick;
        applyStimulus(0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 2'd0);
        out_ready = 1'b0;
        #1;
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick;
            checkOutput($sformatf("bp_hold%0d", c), 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hA000_0000});
            checkOutput($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);
        tick;
        checkOutput("bp_b1", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hA000_0001});
        applyStimulus(0, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 2'd0);
        tick;
        checkOutput("bp_b2", 64'({out_valid, out_eop, out_data}), {30'd0, 2'b11, 32'hA000_0002});
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        tick;
        checkOutput("bp_drain", 64'(out_valid), 64'd0);

        // Src1 packet whose first beat lacks sop
        $display("[TB] missing start-of-packet");
        checkOutput("se_before", 64'(sop_err), 64'd0);
        applyStimulus(1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd1);
        tick;
        checkOutput("se_grant", 64'(grant), 64'd2);
        tick;
        checkOutput("se_beat", 64'({out_valid, out_sop, out_eop, out_empty, out_data}),
                    {27'd0, 3'b101, 2'd1, 32'hDEAD_BEEF});
        checkOutput("se_flag", 64'(sop_err), 64'd1);
`ifdef ST_ARB_CHANNEL_EN
        checkOutput("se_channel", 64'(out_channel), 64'd1);
`endif
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        tick; tick; tick;
        checkOutput("se_sticky", 64'(sop_err), 64'd1);
        checkOutput("se_grant_rel", 64'(grant), 64'd0);

        // Reset after the second beat of a 4-beat src1 packet
        $display("[TB] reset mid-packet");
        applyStimulus(1, 1'b1, 32'hC000_0000, 1'b1, 1'b0, 2'd0);
        tick;
        checkOutput("mr_grant", 64'(grant), 64'd2);
        tick;
        applyStimulus(1, 1'b1, 32'hC000_0001, 1'b0, 1'b0, 2'd0);
        tick;
        checkOutput("mr_b1", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hC000_0001});
        applyStimulus(1, 1'b1, 32'hC000_0002, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mr_out_data", 64'(out_data), 64'd0);
        checkOutput("mr_grant_clr", 64'(grant), 64'd0);
        checkOutput("mr_in_ready", 64'(in_ready), 64'd0);
        checkOutput("mr_sop_err", 64'(sop_err), 64'd0);
        tick;
        reset_n = 1'b1;
        applyStimulus(0, 1'b1, 32'hA100_0000, 1'b1, 1'b1, 2'd0);
        applyStimulus(1, 1'b1, 32'hC100_0000, 1'b1, 1'b1, 2'd0);
        tick;
        checkOutput("mr_next_grant", 64'(grant), 64'd1);
        tick;
        checkOutput("mr_next_beat", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hA100_0000});
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        tick; tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
